// File: rtl/btn_sel_pkg.sv
// Shared types and default constants for the button select controller.
package btn_sel_pkg;
  typedef enum logic {STABLE = 1'b0, COUNTING = 1'b1} db_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int SYNC_STAGES_DEF     = 2;
endpackage

// File: rtl/debounce.sv
// One-bit synchronizer plus debounce FSM; the output is the registered stable level.
module debounce
  import btn_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);
  localparam int              CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_e              r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  // The counter tracks how many consecutive cycles the synced level has differed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= STABLE;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      case (r_state)
        STABLE: begin
          if (w_synced != r_stable) begin
            r_state <= COUNTING;
            r_cnt   <= CW'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        COUNTING: begin
          if (w_synced == r_stable) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_state  <= STABLE;
            r_cnt    <= '0;
            r_stable <= ~r_stable;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/btn_sel_ctrl.sv
// Debounces five buttons into mux/demux selects and enable, and pulses on select changes.
module btn_sel_ctrl
  import btn_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnL,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnR,
  input  logic       btnC,
  output logic [1:0] mux_sel,
  output logic [1:0] demux_sel,
  output logic       en,
  output logic       sel_change
);
  logic [4:0] w_raw;
  logic [4:0] w_db;
  logic [3:0] w_sel;
  logic [3:0] r_prev;
  logic       r_sel_change;

  assign w_raw = {btnC, btnR, btnD, btnU, btnL};

  for (genvar g = 0; g < 5; g++) begin : g_db
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (w_raw[g]),
      .o_stable(w_db[g])
    );
  end

  assign w_sel      = w_db[3:0];
  assign mux_sel    = w_db[1:0];
  assign demux_sel  = w_db[3:2];
  assign en         = w_db[4];
  assign sel_change = r_sel_change;

  // Enable is deliberately excluded from the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= '0;
      r_sel_change <= 1'b0;
    end else begin
      r_prev       <= w_sel;
      r_sel_change <= (w_sel != r_prev);
    end
  end
endmodule

// File: tb/tb_btn_sel_ctrl.sv
// Directed bench for btn_sel_ctrl with a window-based reference model checked every cycle.
module tb_btn_sel_ctrl;
  localparam int D  = 4;
  localparam int SS = 2;
  localparam int N  = SS + D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnL = 1'b0, btnU = 1'b0, btnD = 1'b0, btnR = 1'b0, btnC = 1'b0;
  logic [1:0] mux_sel, demux_sel;
  logic       en, sel_change;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  btn_sel_ctrl #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .btnL(btnL), .btnU(btnU), .btnD(btnD), .btnR(btnR), .btnC(btnC),
    .mux_sel(mux_sel), .demux_sel(demux_sel), .en(en), .sel_change(sel_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the last D synced samples (raw delayed by SS)
  // all equal it and differ from the current output.
  logic [N-1:0] m_samp [5];
  logic [4:0]   m_stb;
  logic [3:0]   m_prev;
  logic         m_chg;

  always @(posedge clk or posedge rst) begin
    logic [4:0]   raw;
    logic [D-1:0] win;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_samp[i] = '0;
      m_stb  = '0;
      m_prev = '0;
      m_chg  = 1'b0;
    end else begin
      raw    = {btnC, btnR, btnD, btnU, btnL};
      m_chg  = (m_stb[3:0] != m_prev);
      m_prev = m_stb[3:0];
      for (int i = 0; i < 5; i++) begin
        m_samp[i] = {m_samp[i][N-2:0], raw[i]};
        win = m_samp[i][N-1:SS];
        if (win == '1 && !m_stb[i]) m_stb[i] = 1'b1;
        else if (win == '0 && m_stb[i]) m_stb[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mux_sel",    int'(mux_sel),    int'(m_stb[1:0]));
    chk("demux_sel",  int'(demux_sel),  int'(m_stb[3:2]));
    chk("en",         int'(en),         int'(m_stb[4]));
    chk("sel_change", int'(sel_change), int'(m_chg));
    if (sel_change) pulses++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Count edges until cond_sig goes high; 21 means it never happened.
  task automatic wait_edges(input int which, output int n);
    n = 21;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if ((which == 0 && mux_sel == 2'b01) ||
          (which == 1 && demux_sel != 2'b00) ||
          (which == 2 && en)) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
  endtask

  initial begin
    int n, p0;
    // Reset with btnL held: outputs cleared before any clock edge.
    btnL = 1'b1;
    #3;
    chk("rst_mux",   int'(mux_sel),    0);
    chk("rst_demux", int'(demux_sel),  0);
    chk("rst_en",    int'(en),         0);
    chk("rst_chg",   int'(sel_change), 0);
    tick(2);
    rst = 1'b0;
    wait_edges(0, n);
    chk("rst_rel_latency", n, 6);
    tick(1);
    chk("rst_rel_pulse", int'(sel_change), 1);
    tick(1);
    chk("rst_rel_pulse_end", int'(sel_change), 0);

    btnL = 1'b0; tick(10);
    chk("l_cleared", int'(mux_sel), 0);

    // Glitch rejection.
    p0 = pulses;
    btnU = 1'b1; tick(3); btnU = 1'b0; tick(12);
    chk("glitch_mux", int'(mux_sel), 0);
    chk("glitch_pulses", pulses - p0, 0);

    // Simultaneous settle of both demux bits.
    p0 = pulses;
    btnD = 1'b1; btnR = 1'b1;
    wait_edges(1, n);
    chk("dual_latency", n, 6);
    chk("dual_value", int'(demux_sel), 3);
    tick(5);
    chk("dual_pulses", pulses - p0, 1);

    // Enable alone produces no select pulse.
    p0 = pulses;
    btnC = 1'b1;
    wait_edges(2, n);
    chk("en_latency", n, 6);
    tick(5);
    chk("en_pulses", pulses - p0, 0);

    // Reset mid-count discards the partial count.
    btnC = 1'b0; btnD = 1'b0; btnR = 1'b0;
    do_reset();
    btnL = 1'b1; tick(2);
    rst = 1'b1; tick(1); rst = 1'b0;
    wait_edges(0, n);
    chk("midrst_latency", n, 6);

    // Sweep all select codes.
    btnL = 1'b0;
    do_reset();
    p0 = pulses;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] code;
      code = 4'(c);
      {btnR, btnD, btnU, btnL} = code;
      tick(10);
      chk("sweep_mux",   int'(mux_sel),   int'(code[1:0]));
      chk("sweep_demux", int'(demux_sel), int'(code[3:2]));
    end
    chk("sweep_pulses", pulses - p0, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_sel_ctrl.md
BTN_SEL_CTRL -- requirements
Module: btn_sel_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive cycles an input must hold a new level before it is accepted (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of each input synchronizer (legal range 2..4).
REQ-003 clk  input  1  system clock, 100 MHz; all state is updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btnL  input  1  raw button, mux select bit 0.
REQ-006 btnU  input  1  raw button, mux select bit 1.
REQ-007 btnD  input  1  raw button, demux select bit 0.
REQ-008 btnR  input  1  raw button, demux select bit 1.
REQ-009 btnC  input  1  raw button, demux output enable.
REQ-010 mux_sel  output  2  debounced {btnU, btnL}; selects the switch nibble.
REQ-011 demux_sel  output  2  debounced {btnR, btnD}; selects the LED nibble.
REQ-012 en  output  1  debounced btnC level; demux output enable.
REQ-013 sel_change  output  1  one-cycle pulse when {demux_sel, mux_sel} changes.

Function
REQ-014 Each of the five raw inputs SHALL pass through its own SYNC_STAGES-deep synchronizer with all stages reset to 0.
REQ-015 Each synchronized input SHALL feed a debouncer with a two-state FSM: STABLE and COUNTING.
REQ-016 In STABLE, when synced input equals the stable value, the debouncer SHALL hold and keep the counter at 0.
REQ-017 In STABLE, when synced input differs from the stable value, the debouncer SHALL move to COUNTING with the counter at 1.
REQ-018 In COUNTING, when synced input returns to the stable value, the debouncer SHALL return to STABLE and clear the counter; the output does not change.
REQ-019 In COUNTING, when synced input still differs and counter == DEBOUNCE_CYCLES-1, the debouncer SHALL flip the stable value, clear the counter and return to STABLE.
REQ-020 In COUNTING otherwise, the counter SHALL increment by 1.
REQ-021 Counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits, and the counter SHALL never wrap.
REQ-022 A clean raw transition held steady SHALL appear on its output exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first rising clk edge that samples it.
REQ-023 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no output change.
REQ-024 mux_sel, demux_sel and en SHALL be the registered stable values, with no combinational path from any raw input.
REQ-025 sel_change SHALL assert for exactly one cycle, on the cycle after any bit of {demux_sel, mux_sel} changes.
REQ-026 Simultaneous changes of several select bits in the same cycle SHALL produce a single sel_change pulse.
REQ-027 A change of en alone SHALL NOT assert sel_change.
REQ-028 Select changes on consecutive cycles SHALL produce back-to-back pulses, one per change cycle.

Reset
REQ-029 On rst assertion, all synchronizer stages, counters and stable values SHALL clear to 0, all FSMs SHALL enter STABLE, and all outputs (mux_sel=0, demux_sel=0, en=0, sel_change=0) SHALL clear immediately, independent of clk.
REQ-030 Reset asserted mid-count SHALL discard the partial count; after release, debouncing restarts from STABLE with stable value 0.
REQ-031 The first rising clk edge after rst deassertion SHALL NOT produce a sel_change pulse.

Structure
REQ-032 A shared package btn_sel_pkg SHALL hold the FSM state typedef (STABLE, COUNTING) and the default constants DEBOUNCE_CYCLES_DEF=1000000 and SYNC_STAGES_DEF=2.
REQ-033 One sub-module, debounce, SHALL implement synchronizer + FSM + counter for one bit, parameterized by DEBOUNCE_CYCLES and SYNC_STAGES, and SHALL be instantiated five times.
REQ-034 Select-change detection (previous-value register and compare) SHALL reside in btn_sel_ctrl.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-035 Reset check: assert rst with btnL=1 held -> all outputs 0 immediately; hold btnL=1, release rst -> mux_sel=01 after exactly 6 clk edges, sel_change high for one cycle after.
REQ-036 Glitch rejection: btnU high for 3 cycles then low -> mux_sel stays 00, sel_change never asserts.
REQ-037 Simultaneous settle: btnD and btnR rise on the same edge and hold -> demux_sel 00->11 on the same cycle, with exactly one sel_change pulse.
REQ-038 Enable only: btnC rises and holds -> en=1 after 6 cycles, sel_change stays 0.
REQ-039 Reset mid-count: btnL rises, rst pulses 2 cycles later, btnL held -> mux_sel=01 exactly 6 cycles after rst release, not earlier.
REQ-040 Sweep: step {btnR,btnD,btnU,btnL} through 0..15, holding each for 10 cycles -> after settling, mux_sel and demux_sel equal the applied codes, with 15 sel_change pulses in total.
